// File: rtl/btn_pkg.sv
// ============================================================================
// Module   : btn_pkg
// Purpose  : Shared types and constants for the debounced button front end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package btn_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int CLK_HZ        = 25_000_000;
    localparam int CYCLES_PER_MS = CLK_HZ / 1000;

    function automatic int ms_to_cycles(input int ms);
        return ms * CYCLES_PER_MS;
    endfunction

    // Counter width able to hold max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce_ch.sv
// ============================================================================
// Module   : btn_debounce_ch
// Purpose  : One button channel: 2-flop synchroniser, debounce FSM and
//            long-press timer with registered level/strobe outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int LONG_CYCLES     = 25000000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int LW = cnt_width(LONG_CYCLES);
    localparam logic [DW-1:0] c_db_last  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] c_long_max = LW'(LONG_CYCLES);
    localparam bit            c_db_one   = (DEBOUNCE_CYCLES == 1);
    localparam bit            c_long_en  = (LONG_CYCLES > 0);

    logic          r_sync1, r_sync2;
    btn_state_t    r_state, w_state_nxt;
    logic [DW-1:0] r_dcnt, w_dcnt_nxt;
    logic [LW-1:0] r_lcnt, w_lcnt_nxt;
    logic          w_level_nxt, w_press_nxt, w_release_nxt, w_long_nxt;
    logic          w_s;

    assign w_s = r_sync2 ^ ACTIVE_LOW;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1   <= ACTIVE_LOW;
            r_sync2   <= ACTIVE_LOW;
            r_state   <= ST_RELEASED;
            r_dcnt    <= '0;
            r_lcnt    <= '0;
            o_level   <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_long    <= 1'b0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_state   <= w_state_nxt;
            r_dcnt    <= w_dcnt_nxt;
            r_lcnt    <= w_lcnt_nxt;
            o_level   <= w_level_nxt;
            o_press   <= w_press_nxt;
            o_release <= w_release_nxt;
            o_long    <= w_long_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_dcnt_nxt    = r_dcnt;
        w_lcnt_nxt    = r_lcnt;
        w_level_nxt   = o_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_long_nxt    = 1'b0;
        unique case (r_state)
            ST_RELEASED: begin
                if (w_s) begin
                    if (c_db_one) begin
                        w_state_nxt = ST_PRESSED;
                        w_level_nxt = 1'b1;
                        w_press_nxt = 1'b1;
                        w_lcnt_nxt  = '0;
                        w_dcnt_nxt  = '0;
                    end else begin
                        w_state_nxt = ST_PRESS_WAIT;
                        w_dcnt_nxt  = DW'(1);
                    end
                end
            end
            ST_PRESS_WAIT: begin
                if (!w_s) begin
                    w_state_nxt = ST_RELEASED;
                    w_dcnt_nxt  = '0;
                end else if (r_dcnt == c_db_last) begin
                    w_state_nxt = ST_PRESSED;
                    w_level_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                    w_lcnt_nxt  = '0;
                    w_dcnt_nxt  = '0;
                end else begin
                    w_dcnt_nxt = r_dcnt + DW'(1);
                end
            end
            ST_PRESSED: begin
                if (!w_s) begin
                    if (c_db_one) begin
                        w_state_nxt   = ST_RELEASED;
                        w_level_nxt   = 1'b0;
                        w_release_nxt = 1'b1;
                        w_dcnt_nxt    = '0;
                    end else begin
                        w_state_nxt = ST_RELEASE_WAIT;
                        w_dcnt_nxt  = DW'(1);
                    end
                end else if (c_long_en && (r_lcnt != c_long_max)) begin
                    // Saturation at c_long_max is what limits o_long to once per press.
                    w_lcnt_nxt = r_lcnt + LW'(1);
                    w_long_nxt = (w_lcnt_nxt == c_long_max);
                end
            end
            ST_RELEASE_WAIT: begin
                if (w_s) begin
                    w_state_nxt = ST_PRESSED;
                    w_dcnt_nxt  = '0;
                end else if (r_dcnt == c_db_last) begin
                    w_state_nxt   = ST_RELEASED;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                    w_dcnt_nxt    = '0;
                end else begin
                    w_dcnt_nxt = r_dcnt + DW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_RELEASED;
                w_dcnt_nxt  = '0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module   : btn_debounce
// Purpose  : Debounced ULX3S button front end, one independent channel per pin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce
    import btn_pkg::*;
#(
    parameter int              NBTN            = 7,
    parameter int              DEBOUNCE_CYCLES = ms_to_cycles(10),
    parameter int              LONG_CYCLES     = ms_to_cycles(1000),
    parameter logic [NBTN-1:0] ACTIVE_LOW_MASK = 7'b0000001
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [NBTN-1:0] i_btn,
    output logic [NBTN-1:0] o_level,
    output logic [NBTN-1:0] o_press,
    output logic [NBTN-1:0] o_release,
    output logic [NBTN-1:0] o_long
);

    for (genvar gi = 0; gi < NBTN; gi++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW_MASK[gi])
        ) u_ch (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_btn     (i_btn[gi]),
            .o_level   (o_level[gi]),
            .o_press   (o_press[gi]),
            .o_release (o_release[gi]),
            .o_long    (o_long[gi])
        );
    end

endmodule

`default_nettype wire
